// File: rtl/immediate_packer.sv
// rtl/immediate_packer.sv - packs a 32-bit immediate into an instruction word's format fields
// Optional feature macro: IMM_PACKER_ERR_COUNT_EN (saturating 16-bit error counter with sync clear)
module immediate_packer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      immediate_source,
  input  logic [XLEN-1:0] imm_value,
  input  logic [XLEN-1:0] base_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic            out_err
`ifdef IMM_PACKER_ERR_COUNT_EN
  ,
  input  logic            err_count_clr,
  output logic [15:0]     err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_B = 3'b010;
  localparam logic [2:0] SRC_J = 3'b011;
  localparam logic [2:0] SRC_U = 3'b100;

  state_t          r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_out_err;
  logic [XLEN-1:0] r_out_instr;
  logic [2:0]      r_src;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_base;

  // Sign-extension checks: the upper bits that the decoder would rebuild
  // from the field's sign bit must all equal that sign bit.
  logic            w_fits_12;
  logic            w_fits_13;
  logic            w_fits_21;
  logic            w_low_zero;
  logic            w_err;
  logic [XLEN-1:0] w_field;
  logic [XLEN-1:0] w_packed;

  assign w_fits_12  = (&r_imm[31:11]) | ~(|r_imm[31:11]);
  assign w_fits_13  = (&r_imm[31:12]) | ~(|r_imm[31:12]);
  assign w_fits_21  = (&r_imm[31:20]) | ~(|r_imm[31:20]);
  assign w_low_zero = ~(|r_imm[11:0]);

  // Representability check and field scatter for the captured request
  always_comb begin
    w_err   = 1'b1;
    w_field = r_base;
    case (r_src)
      SRC_I: begin
        w_err   = ~w_fits_12;
        w_field = {r_imm[11:0], r_base[19:0]};
      end
      SRC_S: begin
        w_err   = ~w_fits_12;
        w_field = {r_imm[11:5], r_base[24:12], r_imm[4:0], r_base[6:0]};
      end
      SRC_B: begin
        w_err   = ~w_fits_13 | r_imm[0];
        w_field = {r_imm[12], r_imm[10:5], r_base[24:12],
                   r_imm[4:1], r_imm[11], r_base[6:0]};
      end
      SRC_J: begin
        w_err   = ~w_fits_21 | r_imm[0];
        w_field = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_base[11:0]};
      end
      SRC_U: begin
        w_err   = ~w_low_zero;
        w_field = {r_imm[31:12], r_base[11:0]};
      end
      default: begin
        w_err   = 1'b1;
        w_field = r_base;
      end
    endcase
  end

  // An unencodable request passes the base word through untouched
  assign w_packed = w_err ? r_base : w_field;

  // Control FSM: capture in IDLE, compute in CHECK, hold result in OUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_err   <= 1'b0;
      r_out_instr <= '0;
      r_src       <= '0;
      r_imm       <= '0;
      r_base      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_src      <= immediate_source;
            r_imm      <= imm_value;
            r_base     <= base_instr;
            r_in_ready <= 1'b0;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          r_out_instr <= w_packed;
          r_out_err   <= w_err;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;

`ifdef IMM_PACKER_ERR_COUNT_EN
  logic [15:0] r_err_count;
  logic        w_err_hs;

  assign w_err_hs = r_out_valid && out_ready && r_out_err;

  // Saturating count of failed encodes; clear takes priority over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (err_count_clr) begin
      r_err_count <= '0;
    end else if (w_err_hs && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule
